// File: rtl/mux_arb_2to1.sv
// Two-requester arbiter for the shared byte mux, with a single-entry valid/ready output stage.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (requester 1 wins ties and preempts OWN2).
module mux_arb_2to1 #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_1,
    input  logic [DATA_W-1:0] data_1,
    output logic              grant_1,
    input  logic              req_2,
    input  logic [DATA_W-1:0] data_2,
    output logic              grant_2,
    output logic              select,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a byte moves downstream on any edge where out_valid && out_ready;
    // the stage accepts a new byte whenever it is empty or is being drained that cycle.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t            state_q, state_d;
    logic              select_q, select_d;
    logic [3:0]        burst_q, burst_d;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              space;
    logic              burst_limit;
    logic              tie_to_1;
    logic [DATA_W-1:0] mux_data;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign tie_to_1 = 1'b1;
`else
    // last_q: 0 = requester 1 served last, 1 = requester 2 served last.
    logic last_q, last_d;
    assign tie_to_1 = last_q;
`endif

    assign space       = !out_valid_q || out_ready;
    assign burst_limit = (burst_q == BURST_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            select_q <= 1'b0;
            burst_q  <= 4'd0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            burst_q  <= burst_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        burst_d  = burst_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_1 && (!req_2 || tie_to_1)) begin
                    state_d  = OWN1;
                    select_d = 1'b0;
                    burst_d  = 4'd0;
`ifndef MUX_ARB_FIXED_PRIO_EN
                    last_d   = 1'b0;
`endif
                end else if (req_2) begin
                    state_d  = OWN2;
                    select_d = 1'b1;
                    burst_d  = 4'd0;
`ifndef MUX_ARB_FIXED_PRIO_EN
                    last_d   = 1'b1;
`endif
                end
            end
            OWN1: begin
                if (grant_1) begin
                    burst_d = burst_limit ? 4'd0 : burst_q + 4'd1;
                end
                if (!req_1 || (grant_1 && burst_limit && req_2)) begin
                    state_d = IDLE;
                end
            end
            OWN2: begin
                if (grant_2) begin
                    burst_d = burst_limit ? 4'd0 : burst_q + 4'd1;
                end
`ifdef MUX_ARB_FIXED_PRIO_EN
                if (!req_2 || req_1) begin
                    state_d = IDLE;
                end
`else
                if (!req_2 || (grant_2 && burst_limit && req_1)) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        grant_1 = (state_q == OWN1) && req_1 && space;
        grant_2 = (state_q == OWN2) && req_2 && space;
        busy    = (state_q != IDLE);
    end

    assign mux_data = select_q ? data_2 : data_1;

    // Output stage: a grant always wins over a drain since space guarantees the old byte leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (grant_1 || grant_2) begin
            out_data_q  <= mux_data;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign select      = select_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Directed bench for mux_arb_2to1 in its default (round-robin) build with MAX_BURST = 4.
module tb_mux_arb_2to1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_1, req_2;
    logic [7:0] data_1, data_2;
    logic       grant_1, grant_2;
    logic       select;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       g1;
        logic       g2;
        logic       sel;
        logic       ov;
        logic       bsy;
        logic [7:0] od;
    } exp_t;

    exp_t fair_exp [12];
    exp_t e;

    mux_arb_2to1 #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_1       (req_1),
        .data_1      (data_1),
        .grant_1     (grant_1),
        .req_2       (req_2),
        .data_2      (data_2),
        .grant_2     (grant_2),
        .select      (select),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected per cycle for both requesters held high: {g1, g2, sel, ov, busy, out_data}
        fair_exp[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        fair_exp[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        fair_exp[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        fair_exp[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        fair_exp[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        fair_exp[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
        fair_exp[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        fair_exp[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        fair_exp[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        fair_exp[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22};
        fair_exp[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
        fair_exp[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};

        rst_n     = 1'b0;
        req_1     = 1'b0;
        req_2     = 1'b0;
        data_1    = 8'h00;
        data_2    = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_select", 32'(select), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant_1", 32'(grant_1), 32'h0);
        check("rst_grant_2", 32'(grant_2), 32'h0);
        rst_n = 1'b1;

        // Single source: arbitration, grant one cycle later, byte the cycle after
        req_1  = 1'b1;
        data_1 = 8'hA5;
        #1;
        check("single_c0_grant_1", 32'(grant_1), 32'h0);
        check("single_c0_busy", 32'(busy), 32'h0);
        tick();
        check("single_c1_grant_1", 32'(grant_1), 32'h1);
        check("single_c1_grant_2", 32'(grant_2), 32'h0);
        check("single_c1_select", 32'(select), 32'h0);
        check("single_c1_busy", 32'(busy), 32'h1);
        check("single_c1_state", 32'(dbg_state), 32'h1);
        tick();
        check("single_c2_out_valid", 32'(out_valid), 32'h1);
        check("single_c2_out_data", 32'(out_data), 32'hA5);
        check("single_c2_grant_2", 32'(grant_2), 32'h0);

        // Reset mid-transfer with a byte held
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_out_data", 32'(out_data), 32'h0);
        check("midrst_select", 32'(select), 32'h0);
        check("midrst_grant_1", 32'(grant_1), 32'h0);
        check("midrst_grant_2", 32'(grant_2), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        req_2  = 1'b1;
        data_1 = 8'h11;
        data_2 = 8'h22;
        #1;
        rst_n = 1'b1;
        check("fair_c0_busy", 32'(busy), 32'h0);

        // Both requesting: 4 to requester 1, IDLE, 4 to requester 2, IDLE, back to 1
        for (int t = 0; t < 12; t++) begin
            tick();
            e = fair_exp[t];
            check($sformatf("fair_t%0d_grant_1", t + 1), 32'(grant_1), 32'(e.g1));
            check($sformatf("fair_t%0d_grant_2", t + 1), 32'(grant_2), 32'(e.g2));
            check($sformatf("fair_t%0d_select", t + 1), 32'(select), 32'(e.sel));
            check($sformatf("fair_t%0d_out_valid", t + 1), 32'(out_valid), 32'(e.ov));
            check($sformatf("fair_t%0d_busy", t + 1), 32'(busy), 32'(e.bsy));
            check($sformatf("fair_t%0d_out_data", t + 1), 32'(out_data), 32'(e.od));
        end

        // Withdraw request 1 before its grant edge: no transfer, back to IDLE
        req_1  = 1'b0;
        data_2 = 8'h30;
        #1;
        check("withdraw_grant_1", 32'(grant_1), 32'h0);
        tick();
        check("withdraw_busy", 32'(busy), 32'h0);
        check("withdraw_out_valid", 32'(out_valid), 32'h0);

        // Backpressure on owner 2 while requester 1 waits
        req_1  = 1'b1;
        data_1 = 8'h40;
        tick();
        check("bp_own2_grant_2", 32'(grant_2), 32'h1);
        check("bp_own2_grant_1", 32'(grant_1), 32'h0);
        check("bp_own2_select", 32'(select), 32'h1);
        check("bp_own2_state", 32'(dbg_state), 32'h2);
        tick();
        data_2 = 8'h31;
        check("bp_first_out_data", 32'(out_data), 32'h30);
        check("bp_first_out_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b0;
        #1;
        check("bp_stall_grant_2", 32'(grant_2), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_stall%0d_out_data", i), 32'(out_data), 32'h30);
            check($sformatf("bp_stall%0d_out_valid", i), 32'(out_valid), 32'h1);
            check($sformatf("bp_stall%0d_grant_2", i), 32'(grant_2), 32'h0);
            check($sformatf("bp_stall%0d_state", i), 32'(dbg_state), 32'h2);
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_grant_2", 32'(grant_2), 32'h1);
        tick();
        data_2 = 8'h32;
        check("bp_r1_out_data", 32'(out_data), 32'h31);
        check("bp_r1_grant_2", 32'(grant_2), 32'h1);
        tick();
        data_2 = 8'h33;
        check("bp_r2_out_data", 32'(out_data), 32'h32);
        check("bp_r2_grant_2", 32'(grant_2), 32'h1);
        check("bp_r2_busy", 32'(busy), 32'h1);
        tick();
        data_2 = 8'h34;
        check("bp_r3_out_data", 32'(out_data), 32'h33);
        check("bp_r3_out_valid", 32'(out_valid), 32'h1);
        check("bp_r3_busy", 32'(busy), 32'h0);
        check("bp_r3_grant_2", 32'(grant_2), 32'h0);

        // Lone owner runs past MAX_BURST without an IDLE gap
        req_2  = 1'b0;
        data_1 = 8'h50;
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("lone%0d_grant_1", i), 32'(grant_1), 32'h1);
            check($sformatf("lone%0d_state", i), 32'(dbg_state), 32'h1);
            if (i > 0) begin
                check($sformatf("lone%0d_out_data", i), 32'(out_data), 32'(8'h50 + i - 1));
            end
            tick();
            data_1 = 8'(8'h51 + i);
        end
        check("lone_last_out_data", 32'(out_data), 32'h59);
        check("lone_last_out_valid", 32'(out_valid), 32'h1);
        req_1 = 1'b0;
        #1;
        check("lone_drop_grant_1", 32'(grant_1), 32'h0);
        tick();
        check("lone_drop_busy", 32'(busy), 32'h0);
        check("lone_drop_out_valid", 32'(out_valid), 32'h0);
        check("lone_drop_select", 32'(select), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arb_2to1.md
Name: mux_arb_2to1

Overview:
- Two-requester arbiter and sequencer for the shared 8-bit 2:1 select datapath.
- Picks which source owns the path, drives the mux select line, and registers the chosen byte into a single-entry output stage.
- Output stage uses a valid/ready handshake.
- Sits between two byte producers and one downstream consumer.

Parameters:
- DATA_W, 8, width of each data input and of out_data.
- MAX_BURST, 4, max consecutive transfers granted to one requester while the other waits; range 1..15.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_1  input  1  requester 1 has a valid byte on data_1.
- data_1  input  DATA_W  requester 1 byte.
- grant_1  output  1  byte on data_1 accepted this cycle.
- req_2  input  1  requester 2 has a valid byte on data_2.
- data_2  input  DATA_W  requester 2 byte.
- grant_2  output  1  byte on data_2 accepted this cycle.
- select  output  1  mux select: 0 = input 1, 1 = input 2.
- out_data  output  DATA_W  registered selected byte.
- out_valid  output  1  out_data holds an unconsumed byte.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  state is not IDLE.

Behaviour:
- **Reset.** rst_n low asynchronously forces:
  - state = IDLE, select = 0, out_data = 0, out_valid = 0;
  - burst count = 0, last-served pointer = 2 (so requester 1 wins the first tie).
- **Reset mid-operation.** Any byte held in the output stage is discarded.
- **States:** IDLE, OWN1, OWN2.
- **Output-stage space:** space = !out_valid || out_ready.
- **Grants:**
  - grant_1 = (state==OWN1) && req_1 && space.
  - grant_2 = (state==OWN2) && req_2 && space.
  - Grants are combinational from registered state and inputs.
  - Each grant is exactly one transfer.
- **select:**
  - Registered; equals 1 in OWN2 and 0 in OWN1.
  - Holds its last value in IDLE.
- **Transfer.** On grant_i, next edge: out_data <= data_i, out_valid <= 1, burst count += 1.
- **Drain.** If out_ready && out_valid and there is no grant, out_valid <= 0 at the edge.
- **Latency.** req asserted in IDLE:
  - cycle 0: arbitration, state update;
  - cycle 1: grant;
  - cycle 2: out_valid high.
- **IDLE transitions:**
  - Only req_1 → OWN1; only req_2 → OWN2.
  - Both → the one not equal to the last-served pointer.
  - Neither → stay in IDLE.
  - On entry to OWN state: burst count = 0, pointer updated.
- **OWNi transitions (evaluated each edge):**
  - Leave to IDLE when req_i is low.
  - Leave to IDLE when burst count reaches MAX_BURST (counted including the current grant) and the other requester is requesting.
  - Otherwise stay.
  - At MAX_BURST with the other requester idle: burst count resets to 0 and ownership continues.
- **IDLE handover.** The IDLE cycle between owners is mandatory; it gives the mux one settle cycle after a select change.
- **Backpressure.** out_ready low with out_valid high:
  - No grants issue; burst count frozen; state held.
  - A requester dropping req while stalled still causes exit to IDLE.
- **Requester rule.** Requesters hold req and data stable until granted. Deasserting req before grant is allowed (request withdrawn, no transfer).
- **busy** = (state != IDLE).

Optional Feature:
- Macro: MUX_ARB_FIXED_PRIO_EN.
- **Defined:**
  - Round-robin pointer is removed; requester 1 always wins ties in IDLE.
  - MAX_BURST limit applies only to OWN1 when req_2 waits.
  - OWN2 is preempted (to IDLE) on the first edge after req_1 rises, regardless of burst count.
- **Undefined:** round-robin with MAX_BURST for both requesters, as above.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with out_valid=1 → out_valid, out_data, select, grant_1/2, busy all 0 immediately; after release, first tie grants requester 1.
- Single source: req_1=1, data_1=0xA5, out_ready=1 → grant_1 on cycle 1, out_data=0xA5, out_valid=1 on cycle 2, select=0, grant_2 never asserted.
- Fairness: req_1=req_2=1 continuously, out_ready=1, MAX_BURST=4 → 4 grants to 1, one IDLE cycle, select→1, 4 grants to 2, repeat; output sequence reflects data_1×4, data_2×4.
- Backpressure: owner 2 streaming, out_ready=0 for 5 cycles → out_data held, no grants, burst count frozen; out_ready=1 resumes with no byte lost or duplicated.
- Lone owner at limit: req_1=1 only for 10 cycles → 10 consecutive grant_1 with no IDLE gap; state stays OWN1.
- With MUX_ARB_FIXED_PRIO_EN: OWN2 active, req_1 rises → next edge IDLE, then OWN1; grant_2 stops within 1 cycle.
